rf_writeback_ctrl: RTL and testbench

RF_WRITEBACK_CTRL -- requirements
Module: rf_writeback_ctrl

---
 rtl/rf_pkg.sv | 21 ++
 rtl/rf_wb_fifo.sv | 64 ++++++
 rtl/rf_writeback_ctrl.sv | 84 ++++++++
 tb/tb_rf_writeback_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback queue entry record.
package rf_pkg;

    localparam int unsigned RIDX_W    = 4;
    localparam int unsigned NREGS     = 16;
    localparam int unsigned RF_DATA_W = 32;

    localparam logic [RIDX_W-1:0] REG_LR = 4'd14;
    localparam logic [RIDX_W-1:0] REG_PC = 4'd15;

    // Data field is sized to the widest supported W; narrower W zero-extends.
    typedef struct packed {
        logic [RIDX_W-1:0]    rd;
        logic [RF_DATA_W-1:0] data;
    } rf_entry_t;

    function automatic logic [NREGS-1:0] onehot_rd(input logic [RIDX_W-1:0] rd);
        return NREGS'(1) << rd;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback request FIFO: storage, wrapping pointers and occupancy count.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              R,
    input  logic                              i_push,
    input  logic                              i_pop,
    input  logic                              i_clear,
    input  rf_entry_t                         i_din,
    output rf_entry_t                         o_head,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic [DEPTH-1:0]                  o_valid,
    output logic [DEPTH-1:0][RIDX_W-1:0]      o_rd_vec
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    rf_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     w_off;

    always_ff @(posedge clock) begin
        if (!R || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // A slot is resident when its distance from the read pointer is below the count.
    always_comb begin
        o_valid  = '0;
        o_rd_vec = '0;
        w_off    = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_off       = AW'(i) - r_rd_ptr;
            o_valid[i]  = CW'(w_off) < r_count;
            o_rd_vec[i] = r_mem[i].rd;
        end
    end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file writeback controller: queued writes, R14/R15 steering, link bypass.
module rf_writeback_ctrl
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic                     clock,
    input  logic                     R,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [3:0]               wb_rd,
    input  logic [W-1:0]             wb_data,
    input  logic                     bl_valid,
    input  logic [W-1:0]             bl_pc4,
    input  logic                     hold,
    input  logic                     flush,
    output logic                     rf_ld,
    output logic [3:0]               rf_rw,
    output logic [W-1:0]             rf_pw,
    output logic                     rf_bl,
    output logic [W-1:0]             rf_pc4,
    output logic [15:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop_pulse
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    rf_entry_t                     w_din;
    rf_entry_t                     w_head;
    logic [CW-1:0]                 w_count;
    logic [DEPTH-1:0]              w_valid;
    logic [DEPTH-1:0][RIDX_W-1:0]  w_rd_vec;
    logic                          w_push;
    logic                          w_deq;
    logic                          w_head_pc;
    logic                          w_link_wins;

    assign w_din.rd   = wb_rd;
    assign w_din.data = RF_DATA_W'(wb_data);

    rf_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .R        (R),
        .i_push   (w_push),
        .i_pop    (w_deq),
        .i_clear  (flush),
        .i_din    (w_din),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_valid  (w_valid),
        .o_rd_vec (w_rd_vec)
    );

    assign wb_ready = R && (w_count < CW'(DEPTH)) && !flush;
    assign w_push   = wb_valid && wb_ready;
    assign w_deq    = R && (w_count != '0) && !hold && !flush;

    // R15 belongs to the PC path; a same-cycle link supersedes a queued R14 write.
    assign w_head_pc   = (w_head.rd == REG_PC);
    assign w_link_wins = (w_head.rd == REG_LR) && bl_valid;

    assign rf_ld      = w_deq && !w_head_pc && !w_link_wins;
    assign drop_pulse = w_deq && (w_head_pc || w_link_wins);
    assign rf_rw      = w_head.rd;
    assign rf_pw      = W'(w_head.data);
    assign count      = w_count;

    assign rf_bl  = bl_valid;
    assign rf_pc4 = bl_pc4;

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_valid[i] && (w_rd_vec[i] != REG_PC)) begin
                busy_mask = busy_mask | onehot_rd(w_rd_vec[i]);
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed and short randomized bench for rf_writeback_ctrl (DEPTH=4, W=32).
module tb_rf_writeback_ctrl;

    logic        clock;
    logic        R;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bl_valid;
    logic [31:0] bl_pc4;
    logic        hold;
    logic        flush;
    logic        rf_ld;
    logic [3:0]  rf_rw;
    logic [31:0] rf_pw;
    logic        rf_bl;
    logic [31:0] rf_pc4;
    logic [15:0] busy_mask;
    logic [2:0]  count;
    logic        drop_pulse;

    int n_checks = 0;
    int n_err    = 0;
    int n_writes = 0;
    int n_drops  = 0;
    logic [31:0] rf_model [16];

    rf_writeback_ctrl #(.DEPTH(4), .W(32)) dut (
        .clock(clock), .R(R), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .bl_valid(bl_valid), .bl_pc4(bl_pc4),
        .hold(hold), .flush(flush), .rf_ld(rf_ld), .rf_rw(rf_rw), .rf_pw(rf_pw),
        .rf_bl(rf_bl), .rf_pc4(rf_pc4), .busy_mask(busy_mask), .count(count),
        .drop_pulse(drop_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file that consumes the DUT's write ports.
    always @(posedge clock) begin
        if (rf_ld) begin
            rf_model[rf_rw] <= rf_pw;
            n_writes <= n_writes + 1;
        end
        if (rf_bl) rf_model[14] <= rf_pc4;
        if (drop_pulse) n_drops <= n_drops + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] rd, input logic [31:0] d,
                        input logic h, input logic f, input logic bl, input logic [31:0] pc4);
        @(negedge clock);
        wb_valid = v; wb_rd = rd; wb_data = d; hold = h; flush = f;
        bl_valid = bl; bl_pc4 = pc4;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [3:0]  q_rd [$];
    logic [31:0] q_data [$];
    int wr0, dr0;

    initial begin
        R = 1'b0; wb_valid = 0; wb_rd = 0; wb_data = 0; hold = 0; flush = 0;
        bl_valid = 0; bl_pc4 = 0;
        for (int i = 0; i < 16; i++) rf_model[i] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock); R = 1'b1; #1;
        chk("rst_count", 64'(count), 0);
        chk("rst_busy", 64'(busy_mask), 0);
        chk("rst_ld", 64'(rf_ld), 0);
        chk("rst_drop", 64'(drop_pulse), 0);
        chk("rst_ready", 64'(wb_ready), 1);

        // Single write R3, one-cycle latency, busy for one cycle
        step(1, 4'd3, 32'h30303030, 0, 0, 0, 0);
        chk("r3_ld_early", 64'(rf_ld), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("r3_ld", 64'(rf_ld), 1);
        chk("r3_rw", 64'(rf_rw), 3);
        chk("r3_pw", 64'(rf_pw), 64'h30303030);
        chk("r3_busy", 64'(busy_mask), 64'h0008);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("r3_busy_clr", 64'(busy_mask), 0);
        chk("r3_ld_done", 64'(rf_ld), 0);
        chk("r3_model", 64'(rf_model[3]), 64'h30303030);

        // Fill under hold: five requests, four accepted
        for (int i = 0; i < 5; i++) begin
            step(1, 4'(i), 32'h01010101 * (i + 1), 1, 0, 0, 0);
            chk($sformatf("fill_ready%0d", i), 64'(wb_ready), (i < 4) ? 1 : 0);
            chk($sformatf("fill_count%0d", i), 64'(count), 64'(i < 4 ? i : 4));
            chk($sformatf("fill_ld%0d", i), 64'(rf_ld), 0);
        end
        step(0, 0, 0, 1, 0, 0, 0);
        chk("full_count", 64'(count), 4);
        chk("full_busy", 64'(busy_mask), 64'h000F);
        chk("full_ready", 64'(wb_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("drain_ld%0d", k), 64'(rf_ld), 1);
            chk($sformatf("drain_rw%0d", k), 64'(rf_rw), 64'(k));
            chk($sformatf("drain_pw%0d", k), 64'(rf_pw), 64'(32'h01010101 * (k + 1)));
            if (k == 0) chk("drain_ready_full", 64'(wb_ready), 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drain_count", 64'(count), 0);

        // R14 without link is written normally
        step(1, 4'd14, 32'h22222222, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("lr_ld", 64'(rf_ld), 1);
        chk("lr_rw", 64'(rf_rw), 14);
        chk("lr_busy", 64'(busy_mask), 64'h4000);

        // R14 retiring with same-cycle link: link wins, entry dropped
        step(1, 4'd14, 32'h11111111, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h00000104);
        chk("bl_ld", 64'(rf_ld), 0);
        chk("bl_rfbl", 64'(rf_bl), 1);
        chk("bl_pc4", 64'(rf_pc4), 64'h104);
        chk("bl_drop", 64'(drop_pulse), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("bl_drop_end", 64'(drop_pulse), 0);
        chk("bl_count", 64'(count), 0);
        chk("bl_r14", 64'(rf_model[14]), 64'h104);

        // rd=15 request is discarded
        step(1, 4'd15, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pc_ld", 64'(rf_ld), 0);
        chk("pc_drop", 64'(drop_pulse), 1);
        chk("pc_busy", 64'(busy_mask), 0);
        chk("pc_count1", 64'(count), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pc_count0", 64'(count), 0);
        chk("pc_drop_end", 64'(drop_pulse), 0);

        // Flush three queued entries with a colliding request
        for (int i = 5; i < 8; i++) step(1, 4'(i), 32'(i), 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("fl_count3", 64'(count), 3);
        chk("fl_busy3", 64'(busy_mask), 64'h00E0);
        wr0 = n_writes; dr0 = n_drops;
        step(1, 4'd8, 32'h88, 0, 1, 0, 0);
        chk("fl_ready", 64'(wb_ready), 0);
        chk("fl_ld", 64'(rf_ld), 0);
        chk("fl_drop", 64'(drop_pulse), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("fl_count0", 64'(count), 0);
        chk("fl_busy0", 64'(busy_mask), 0);
        chk("fl_ld_after", 64'(rf_ld), 0);
        chk("fl_writes", 64'(n_writes), 64'(wr0));
        chk("fl_drops", 64'(n_drops), 64'(dr0));

        // Reset mid-operation with two entries queued
        step(1, 4'd1, 32'hA1, 1, 0, 0, 0);
        step(1, 4'd2, 32'hA2, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("mr_count2", 64'(count), 2);
        wr0 = n_writes; dr0 = n_drops;
        @(negedge clock);
        R = 1'b0; hold = 0; bl_valid = 1; bl_pc4 = 32'h200;
        #1;
        chk("mr_ld", 64'(rf_ld), 0);
        chk("mr_drop", 64'(drop_pulse), 0);
        chk("mr_rfbl", 64'(rf_bl), 1);
        step(0, 0, 0, 0, 0, 0, 0);
        R = 1'b1; #1;
        chk("mr_count0", 64'(count), 0);
        chk("mr_busy0", 64'(busy_mask), 0);
        chk("mr_ready", 64'(wb_ready), 1);
        chk("mr_writes", 64'(n_writes), 64'(wr0));
        chk("mr_drops", 64'(n_drops), 64'(dr0));

        // Random enqueue/dequeue against a reference queue
        for (int c = 0; c < 10; c++) begin
            logic v, h, exp_push, exp_pop;
            logic [3:0] rd;
            logic [31:0] d;
            v  = 1'($urandom_range(1, 0));
            h  = ($urandom_range(3, 0) == 0);
            rd = 4'($urandom_range(13, 0));
            d  = $urandom;
            step(v, rd, d, h, 0, 0, 0);
            exp_push = v && (q_rd.size() < 4);
            exp_pop  = (q_rd.size() > 0) && !h;
            chk($sformatf("rnd_count%0d", c), 64'(count), 64'(q_rd.size()));
            chk($sformatf("rnd_ready%0d", c), 64'(wb_ready), (q_rd.size() < 4) ? 1 : 0);
            chk($sformatf("rnd_ld%0d", c), 64'(rf_ld), 64'(exp_pop));
            if (exp_pop) begin
                chk($sformatf("rnd_rw%0d", c), 64'(rf_rw), 64'(q_rd[0]));
                chk($sformatf("rnd_pw%0d", c), 64'(rf_pw), 64'(q_data[0]));
                void'(q_rd.pop_front());
                void'(q_data.pop_front());
            end
            if (exp_push) begin
                q_rd.push_back(rd);
                q_data.push_back(d);
            end
        end
        step(0, 0, 0, 1, 0, 0, 0);
        chk("rnd_final_count", 64'(count), 64'(q_rd.size()));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
